// File: rtl/shift_operand_loader.sv
// shift_operand_loader
//   Assembles an 8-bit operand (low nibble, then high nibble) and a 3-bit shift
//   magnitude from three 4-bit transfers. The result is presented to the barrel
//   shifter as one registered word with a valid/ready handshake.
//
//   Optional feature macro: SHIFT_LOADER_SWEEP_EN
//     When defined, bit 3 of the magnitude nibble requests a sweep. Each
//     handshake then steps shift_mag_o up by one until it reaches its maximum.
//
//   state | meaning
//   ------+-----------------------------------------------
//   S_LO  | waiting for the low operand nibble
//   S_HI  | waiting for the high operand nibble
//   S_MAG | waiting for the magnitude nibble
//   S_OUT | presenting ip_o/shift_mag_o, waiting for the consumer
module shift_operand_loader #(
  parameter int NIB_W  = 4,
  parameter int DATA_W = 8,
  parameter int MAG_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NIB_W-1:0]  nib_i,
  input  logic              nib_valid_i,
  input  logic              abort_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] ip_o,
  output logic [MAG_W-1:0]  shift_mag_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
);

  typedef enum logic [1:0] {
    S_LO  = 2'd0,
    S_HI  = 2'd1,
    S_MAG = 2'd2,
    S_OUT = 2'd3
  } state_t;

  state_t           state;
  logic [NIB_W-1:0] lo;
  logic [NIB_W-1:0] hi;
`ifdef SHIFT_LOADER_SWEEP_EN
  logic             sweep;
`endif

  localparam logic [MAG_W-1:0] MAG_MAX = '1;

  logic nib_xfer;
  logic out_xfer;

  // Ready is a pure state decode, so it reads 1 while the block is held in reset.
  always_comb begin
    in_ready_o = (state != S_OUT);
    nib_xfer   = nib_valid_i && in_ready_o;
    out_xfer   = out_valid_o && out_ready_i;
  end

  // Loader FSM: nibble assembly, word presentation, optional magnitude sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_LO;
      lo          <= '0;
      hi          <= '0;
      ip_o        <= '0;
      shift_mag_o <= '0;
      out_valid_o <= 1'b0;
`ifdef SHIFT_LOADER_SWEEP_EN
      sweep       <= 1'b0;
`endif
    end else if (abort_i) begin
      // Abort wins over any transfer; the last presented word stays on ip_o/shift_mag_o.
      state       <= S_LO;
      lo          <= '0;
      hi          <= '0;
      out_valid_o <= 1'b0;
`ifdef SHIFT_LOADER_SWEEP_EN
      sweep       <= 1'b0;
`endif
    end else begin
      case (state)
        S_LO: begin
          if (nib_xfer) begin
            lo    <= nib_i;
            state <= S_HI;
          end
        end
        S_HI: begin
          if (nib_xfer) begin
            hi    <= nib_i;
            state <= S_MAG;
          end
        end
        S_MAG: begin
          if (nib_xfer) begin
            // Upper magnitude bits are simply dropped, so 8..15 wrap to 0..7.
            ip_o        <= {hi, lo};
            shift_mag_o <= nib_i[MAG_W-1:0];
            out_valid_o <= 1'b1;
            state       <= S_OUT;
`ifdef SHIFT_LOADER_SWEEP_EN
            sweep       <= nib_i[NIB_W-1];
`endif
          end
        end
        S_OUT: begin
          if (out_xfer) begin
`ifdef SHIFT_LOADER_SWEEP_EN
            if (sweep && (shift_mag_o != MAG_MAX)) begin
              shift_mag_o <= shift_mag_o + MAG_W'(1);
            end else begin
              sweep       <= 1'b0;
              out_valid_o <= 1'b0;
              state       <= S_LO;
            end
`else
            out_valid_o <= 1'b0;
            state       <= S_LO;
`endif
          end
        end
        default: begin
          state       <= S_LO;
          out_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_operand_loader.sv
// Scoreboard bench for shift_operand_loader: stimulus pushes expected words,
// a negedge monitor pops one per output handshake.
module tb_shift_operand_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] nib_i;
  logic       nib_valid_i;
  logic       abort_i;
  logic       in_ready_o;
  logic [7:0] ip_o;
  logic [2:0] shift_mag_o;
  logic       out_valid_o;
  logic       out_ready_i;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  shift_operand_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .nib_i       (nib_i),
    .nib_valid_i (nib_valid_i),
    .abort_i     (abort_i),
    .in_ready_o  (in_ready_o),
    .ip_o        (ip_o),
    .shift_mag_o (shift_mag_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid_o && out_ready_i) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got ip=0x%0h mag=%0d with empty scoreboard", ip_o, shift_mag_o);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        chk("word_ip", {24'd0, ip_o}, {24'd0, e[10:3]});
        chk("word_mag", {29'd0, shift_mag_o}, {29'd0, e[2:0]});
      end
    end
  end

  task automatic push(input logic [7:0] ip, input logic [2:0] mag);
    exp_q.push_back({ip, mag});
  endtask

  // Called at posedge+1; waits (bounded) for in_ready, transfers one nibble.
  task automatic send_nib(input logic [3:0] n);
    int t;
    t = 0;
    while (!in_ready_o && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready_o) chk("send_timeout", 32'd1, 32'd0);
    nib_i       = n;
    nib_valid_i = 1'b1;
    @(posedge clk); #1;
    nib_valid_i = 1'b0;
    nib_i       = 4'h0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (out_valid_o && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (out_valid_o) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int hs0;
    rst_n       = 1'b0;
    nib_i       = 4'h0;
    nib_valid_i = 1'b0;
    abort_i     = 1'b0;
    out_ready_i = 1'b0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_ip", {24'd0, ip_o}, 32'd0);
    chk("rst_mag", {29'd0, shift_mag_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: basic load, consumer always ready
    out_ready_i = 1'b1;
    push(8'h10, 3'd2);
    send_nib(4'h0);
    send_nib(4'h1);
    send_nib(4'h2);
    chk("t1_valid_rise", {31'd0, out_valid_o}, 32'd1);
    chk("t1_in_ready_low", {31'd0, in_ready_o}, 32'd0);
    @(posedge clk); #1;
    chk("t1_valid_one_cycle", {31'd0, out_valid_o}, 32'd0);
    chk("t1_in_ready_back", {31'd0, in_ready_o}, 32'd1);

    // 2: back-pressure; stray nibbles ignored while presenting
    out_ready_i = 1'b0;
    push(8'h2C, 3'd1);
    send_nib(4'hC);
    send_nib(4'h2);
    send_nib(4'h1);
    for (int i = 0; i < 5; i++) begin
      nib_i = 4'hF;
      nib_valid_i = 1'b1;
      chk("t2_hold_valid", {31'd0, out_valid_o}, 32'd1);
      chk("t2_hold_ip", {24'd0, ip_o}, 32'h2C);
      chk("t2_hold_mag", {29'd0, shift_mag_o}, 32'd1);
      chk("t2_in_ready", {31'd0, in_ready_o}, 32'd0);
      @(posedge clk); #1;
    end
    nib_valid_i = 1'b0;
    out_ready_i = 1'b1;
    hs0 = hs_cnt;
    @(posedge clk); #1;
    chk("t2_released", {31'd0, out_valid_o}, 32'd0);
    chk("t2_handshakes", hs_cnt - hs0, 32'd1);

    // 3: abort discards a partial load
    send_nib(4'h6);
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    push(8'h0A, 3'd2);
    send_nib(4'hA);
    send_nib(4'h0);
    send_nib(4'h2);
    wait_idle();

    // 4: async reset mid-load and mid-present
    send_nib(4'h1);
    send_nib(4'h2);
    rst_n = 1'b0;
    #1;
    chk("t4a_ip", {24'd0, ip_o}, 32'd0);
    chk("t4a_mag", {29'd0, shift_mag_o}, 32'd0);
    chk("t4a_in_ready", {31'd0, in_ready_o}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready_i = 1'b0;
    send_nib(4'h3);
    send_nib(4'h5);
    send_nib(4'h1);
    chk("t4_pre_valid", {31'd0, out_valid_o}, 32'd1);
    chk("t4_pre_ip", {24'd0, ip_o}, 32'h53);
    rst_n = 1'b0;
    #1;
    chk("t4b_valid", {31'd0, out_valid_o}, 32'd0);
    chk("t4b_ip", {24'd0, ip_o}, 32'd0);
    chk("t4b_mag", {29'd0, shift_mag_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    // The lo/hi from before reset must not leak: first nibble is the new low.
    push(8'h04, 3'd2);
    send_nib(4'h4);
    send_nib(4'h0);
    send_nib(4'h2);
    wait_idle();

    // 5: sweep request bit on magnitude nibble 0xA
    hs0 = hs_cnt;
`ifdef SHIFT_LOADER_SWEEP_EN
    for (int m = 2; m <= 7; m++) push(8'h06, 3'(m));
`else
    push(8'h06, 3'd2);
`endif
    send_nib(4'h6);
    send_nib(4'h0);
    send_nib(4'hA);
    wait_idle();
`ifdef SHIFT_LOADER_SWEEP_EN
    chk("t5_handshakes", hs_cnt - hs0, 32'd6);
`else
    chk("t5_handshakes", hs_cnt - hs0, 32'd1);
`endif

    // 6: magnitude 0x9 wraps to 1
    hs0 = hs_cnt;
`ifdef SHIFT_LOADER_SWEEP_EN
    for (int m = 1; m <= 7; m++) push(8'h05, 3'(m));
`else
    push(8'h05, 3'd1);
`endif
    send_nib(4'h5);
    send_nib(4'h0);
    send_nib(4'h9);
    wait_idle();
`ifdef SHIFT_LOADER_SWEEP_EN
    chk("t6_handshakes", hs_cnt - hs0, 32'd7);
`else
    chk("t6_handshakes", hs_cnt - hs0, 32'd1);
`endif

    @(posedge clk); #1;
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
